// File: rtl/ap_ctrl_hs_driver.sv
// Initiator side of the ap_ctrl_hs handshake: issues a run of transactions, bounds outstanding work, measures latency.
// Optional watchdog enabled by defining AP_CTRL_HS_DRIVER_WATCHDOG_EN.
module ap_ctrl_hs_driver #(
  parameter int CNT_W       = 32,
  parameter int TXN_W       = 16,
  parameter int MAX_OUT     = 2,
  parameter int WDOG_CYCLES = 65536
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [TXN_W-1:0] txn_count,
  output logic             ap_start,
  output logic             ap_continue,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             busy,
  output logic             finish,
  output logic [TXN_W-1:0] issued,
  output logic [TXN_W-1:0] completed,
  output logic [CNT_W-1:0] last_latency,
  output logic [CNT_W-1:0] max_latency,
  output logic             protocol_err,
  output logic             timeout_err
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
  state_t state_reg, state_next;

  logic [CNT_W-1:0] cyc_reg, ts_reg, push_ts, pop_ts, latency;
  logic             ts_held_reg;
  logic [CNT_W-1:0] mem_reg [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [OUT_W-1:0] out_reg;
  logic [TXN_W-1:0] txn_reg, issued_reg, completed_reg, issued_next, completed_next;
  logic [CNT_W-1:0] last_lat_reg, max_lat_reg;
  logic             busy_reg, finish_reg, perr_reg;
  logic             start, accept, active, pop, go_ok, wd_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    active         = (state_reg == ISSUE) || (state_reg == DRAIN);
    go_ok          = go && ((state_reg == IDLE) || (state_reg == FIN));
    start          = (state_reg == ISSUE) && (out_reg < OUT_W'(MAX_OUT));
    accept         = start && ap_ready;
    // Timestamp is the first cycle ap_start was high for this transaction.
    push_ts        = ts_held_reg ? ts_reg : cyc_reg;
    // An empty FIFO with a same-cycle accept pops the entry being pushed.
    pop            = active && ap_done && ((out_reg != '0) || accept);
    pop_ts         = (out_reg != '0) ? mem_reg[rd_ptr_reg] : push_ts;
    latency        = cyc_reg - pop_ts;
    issued_next    = issued_reg + TXN_W'(accept);
    completed_next = completed_reg + TXN_W'(pop);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FIN: if (go_ok) state_next = (txn_count != '0) ? ISSUE : FIN;
      ISSUE:     if (issued_next == txn_reg)
                   state_next = (completed_next == txn_reg) ? FIN : DRAIN;
      DRAIN:     if (completed_next == txn_reg) state_next = FIN;
      default:   state_next = IDLE;
    endcase
    if (wd_fire) state_next = FIN;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUT; i++) mem_reg[i] <= '0;
    end else if (accept) begin
      mem_reg[wr_ptr_reg] <= push_ts;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cyc_reg       <= '0;
      ts_reg        <= '0;
      ts_held_reg   <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      out_reg       <= '0;
      txn_reg       <= '0;
      issued_reg    <= '0;
      completed_reg <= '0;
      last_lat_reg  <= '0;
      max_lat_reg   <= '0;
      busy_reg      <= 1'b0;
      finish_reg    <= 1'b0;
      perr_reg      <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_reg + 1'b1;
      busy_reg   <= (state_next == ISSUE) || (state_next == DRAIN);
      finish_reg <= (state_next == FIN);
      if (go_ok) begin
        txn_reg       <= txn_count;
        issued_reg    <= '0;
        completed_reg <= '0;
        max_lat_reg   <= '0;
        perr_reg      <= 1'b0;
        wr_ptr_reg    <= '0;
        rd_ptr_reg    <= '0;
        out_reg       <= '0;
        ts_held_reg   <= 1'b0;
      end else if (active) begin
        issued_reg    <= issued_next;
        completed_reg <= completed_next;
        if (accept) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        if (accept && !pop) out_reg <= out_reg + 1'b1;
        else if (pop && !accept) out_reg <= out_reg - 1'b1;
        ts_held_reg <= start && !ap_ready && !wd_fire;
        if (start && !ap_ready && !ts_held_reg) ts_reg <= cyc_reg;
        if (pop) begin
          last_lat_reg <= latency;
          if (latency > max_lat_reg) max_lat_reg <= latency;
        end
        if (ap_done && !pop) perr_reg <= 1'b1;
      end
    end
  end

`ifdef AP_CTRL_HS_DRIVER_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_reg;
  logic            timeout_reg;

  // Fires on the WDOG_CYCLES-th consecutive cycle without an accept or a done.
  assign wd_fire = active && !accept && !ap_done && (wd_reg == WD_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else if (go_ok) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else if (active) begin
      wd_reg <= (accept || ap_done) ? '0 : wd_reg + 1'b1;
      if (wd_fire) timeout_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_reg;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ap_start     = start;
  assign ap_continue  = busy_reg;
  assign busy         = busy_reg;
  assign finish       = finish_reg;
  assign issued       = issued_reg;
  assign completed    = completed_reg;
  assign last_latency = last_lat_reg;
  assign max_latency  = max_lat_reg;
  assign protocol_err = perr_reg;

endmodule
